// File: rtl/stack_mem_responder.sv
// Memory-side responder for the 8-bit stack-machine CPU: combinational reads,
// 0xFF-marker store decode, byte-serial program loader and CPU reset control.
module stack_mem_responder #(
  parameter int         ADDR_W   = 5,
  parameter logic [7:0] OOR_DATA = 8'h0F
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        cpu_mem_addr,
  input  logic [7:0]        cpu_data_out,
  output logic [7:0]        cpu_data_in,
  output logic              cpu_reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  input  logic              run_stop,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data,
  output logic              busy
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              armed, armed_nxt;
  logic              cpu_in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        mem [DEPTH];

  // The CPU samples read data on the same edge it drives the address.
  assign cpu_in_range = ({1'b0, cpu_mem_addr} < DEPTH_9);
  assign cpu_data_in  = cpu_in_range ? mem[cpu_mem_addr[ADDR_W-1:0]] : OOR_DATA;
  assign dbg_data     = mem[dbg_addr];
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = cnt;
    wr_data   = load_data;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          wr_en = 1'b1;
          // Counter saturates at the top word; a full memory ends the load.
          if (load_last || (cnt == '1)) state_nxt = RUN;
          else                          cnt_nxt   = cnt + ADDR_W'(1);
        end
      end
      RUN: begin
        if (run_stop) begin
          state_nxt = IDLE;
        end else if (armed) begin
          // Data cycle of a store: never re-arms, so storing 0xFF is safe.
          wr_en   = cpu_in_range;
          wr_addr = cpu_mem_addr[ADDR_W-1:0];
          wr_data = cpu_data_out;
        end else begin
          armed_nxt = (cpu_data_out == 8'hFF);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      armed     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      armed     <= armed_nxt;
      cpu_reset <= (state_nxt != RUN);
    end
  end

  // Memory contents are part of the reset state: an aborted load is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= OOR_DATA;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_stack_mem_responder.sv
// Self-checking bench for stack_mem_responder: directed scenarios plus random
// traffic, all checked against a behavioural model of the memory and controller.
module tb_stack_mem_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpu_mem_addr = 8'h00;
  logic [7:0] cpu_data_out = 8'h00;
  logic [7:0] cpu_data_in;
  logic       cpu_reset;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       run_stop = 1'b0;
  logic [4:0] dbg_addr = 5'd0;
  logic [7:0] dbg_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  stack_mem_responder #(.ADDR_W(5), .OOR_DATA(8'h0F)) dut (
    .clock(clock), .reset(reset),
    .cpu_mem_addr(cpu_mem_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_in(cpu_data_in), .cpu_reset(cpu_reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .run_stop(run_stop),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural model: mode 0 idle, 1 loading, 2 running.
  int         ms = 0;
  logic [7:0] m [32];
  int         mcnt = 0;
  bit         marmed = 1'b0;
  bit         mcpu_reset = 1'b1;

  always @(posedge clock) begin : model
    int ns;
    bit na;
    ns = ms;
    na = 1'b0;
    if (reset) begin
      for (int i = 0; i < 32; i++) m[i] <= 8'h0F;
      ms <= 0; mcnt <= 0; marmed <= 1'b0; mcpu_reset <= 1'b1;
    end else begin
      if (ms == 0 && load_start) begin
        ns = 1;
        mcnt <= 0;
      end else if (ms == 1 && load_valid) begin
        m[mcnt] <= load_data;
        if (load_last || mcnt == 31) ns = 2;
        else mcnt <= mcnt + 1;
      end else if (ms == 2) begin
        if (run_stop) ns = 0;
        else if (marmed) begin
          if (cpu_mem_addr < 8'd32) m[cpu_mem_addr[4:0]] <= cpu_data_out;
        end else na = (cpu_data_out == 8'hFF);
      end
      ms <= ns; marmed <= na; mcpu_reset <= (ns != 2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(ms != 0));
      chk("cpu_reset", 32'(cpu_reset), 32'(mcpu_reset));
      chk("cpu_data_in", 32'(cpu_data_in),
          32'((cpu_mem_addr < 8'd32) ? m[cpu_mem_addr[4:0]] : 8'h0F));
      chk("dbg_data", 32'(dbg_data), 32'(m[dbg_addr]));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus(input logic [7:0] a, input logic [7:0] d);
    cpu_mem_addr = a;
    cpu_data_out = d;
    step();
  endtask

  task automatic sweep_const(input string nm, input logic [7:0] v);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      @(negedge clock);
      chk(nm, 32'(dbg_data), 32'(v));
    end
  endtask

  task automatic peek(input string nm, input logic [4:0] a, input logic [7:0] v);
    dbg_addr = a;
    #1;
    chk(nm, 32'(dbg_data), 32'(v));
  endtask

  task automatic load_bytes(input logic [7:0] q[$], input bit use_last);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      load_valid = 1'b1;
      load_data  = q[i];
      load_last  = use_last && (i == q.size() - 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0] prog[$];
  logic [7:0] full[$];
  logic [7:0] prog_exp [8];

  initial begin
    prog = '{8'h08, 8'h03, 8'h08, 8'h04, 8'h00, 8'h0A, 8'h1F, 8'h0E};
    prog_exp = '{8'h08, 8'h03, 8'h08, 8'h04, 8'h00, 8'h0A, 8'h1F, 8'h0E};
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;

    // After reset
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    sweep_const("rst_mem", 8'h0F);

    // Program load and scripted CPU bus activity
    step();
    load_bytes(prog, 1'b1);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cpu_mem_addr = 8'(i);
      cpu_data_out = 8'h00;
      #1;
      chk("fetch", 32'(cpu_data_in), 32'(prog_exp[i]));
      step();
      chk("run_cpu_reset_hold", 32'(cpu_reset), 32'd0);
    end
    bus(8'h06, 8'hFF);
    bus(8'h1F, 8'h07);
    bus(8'h07, 8'hFF);
    bus(8'h07, 8'hFF);
    bus(8'h00, 8'h00);
    chk("str_cpu_reset", 32'(cpu_reset), 32'd0);
    peek("str_result", 5'h1F, 8'h07);
    peek("ret_rewrite", 5'h07, 8'hFF);

    // Forced bus: marker then data, and storing 0xFF
    bus(8'h02, 8'hFF); bus(8'h10, 8'h55); bus(8'h00, 8'h00);
    peek("st_55", 5'h10, 8'h55);
    peek("st_marker_addr", 5'h02, 8'h08);
    bus(8'h02, 8'hFF); bus(8'h11, 8'hFF); bus(8'h00, 8'h00);
    peek("st_ff", 5'h11, 8'hFF);
    peek("st_no_rearm", 5'h00, 8'h08);

    // Out-of-range read and write
    cpu_mem_addr = 8'h40;
    cpu_data_out = 8'h00;
    #1;
    chk("oor_read", 32'(cpu_data_in), 32'h0F);
    bus(8'h40, 8'hFF); bus(8'h40, 8'h12); bus(8'h00, 8'h00);
    peek("oor_nowrite0", 5'h00, 8'h08);
    peek("oor_nowrite1", 5'h01, 8'h03);

    // Full 32-byte load without last
    run_stop = 1'b1; step(); run_stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_cpu_reset", 32'(cpu_reset), 32'd1);
    for (int i = 0; i < 32; i++) full.push_back(8'($urandom_range(0, 254)));
    load_bytes(full, 1'b0);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_cpu_reset", 32'(cpu_reset), 32'd0);
    peek("full_last", 5'd31, full[31]);
    load_valid = 1'b1; load_data = 8'hEE; step(); load_valid = 1'b0;
    peek("extra_ignored0", 5'd0, full[0]);
    peek("extra_ignored31", 5'd31, full[31]);

    // run_stop on the data cycle of a store
    bus(8'h03, 8'hFF);
    cpu_mem_addr = 8'h05; cpu_data_out = 8'hAA; run_stop = 1'b1;
    step();
    run_stop = 1'b0; cpu_data_out = 8'h00;
    chk("stopwr_busy", 32'(busy), 32'd0);
    chk("stopwr_cpu_reset", 32'(cpu_reset), 32'd1);
    peek("stopwr_nowrite", 5'd5, full[5]);

    // Reset during load
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h33; step(); step();
    load_valid = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstload_busy", 32'(busy), 32'd0);
    chk("rstload_cpu_reset", 32'(cpu_reset), 32'd1);
    sweep_const("rstload_mem", 8'h0F);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 399) == 0);
      load_start   = ($urandom_range(0, 19) == 0);
      load_valid   = ($urandom_range(0, 1) == 0);
      load_data    = 8'($urandom_range(0, 255));
      load_last    = ($urandom_range(0, 9) == 0);
      run_stop     = ($urandom_range(0, 59) == 0);
      cpu_mem_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 31));
      cpu_data_out = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      dbg_addr     = 5'($urandom_range(0, 31));
      step();
    end
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; run_stop = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_mem_responder.md
Name: stack_mem_responder

Overview:
Memory-side responder for the 8-bit stack-machine CPU bus. It serves combinational reads on `cpu_mem_addr` and decodes the CPU's store convention: an 0xFF marker cycle followed by a data cycle. It also owns a byte-serial program loader and holds the CPU in reset until a program has been loaded. It sits beside the CPU core at chip top, between the core and the pad-level load/debug interface.

Parameters:
ADDR_W, 5, memory address width; depth = 2**ADDR_W words of 8 bits.
OOR_DATA, 8'h0F, value returned for reads at or above depth (0x0F is the NUL opcode).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
cpu_mem_addr  input  8  CPU address bus
cpu_data_out  input  8  CPU write-data / marker bus
cpu_data_in  output  8  read data to CPU (combinational)
cpu_reset  output  1  registered reset to the CPU core
load_start  input  1  pulse: begin program load
load_valid  input  1  `load_data` valid this cycle
load_data  input  8  program byte
load_last  input  1  qualifies `load_valid`: final byte
run_stop  input  1  pulse: return to IDLE
dbg_addr  input  ADDR_W  debug read address
dbg_data  output  8  mem[`dbg_addr`] (combinational, any state)
busy  output  1  high in LOAD or RUN

Behaviour:
- Reset state:
  - state=IDLE; all memory words = OOR_DATA.
  - load counter=0; write marker `armed`=0.
  - `cpu_reset`=1, `busy`=0.
- Controller FSM (IDLE, LOAD, RUN):
  - IDLE→LOAD on `load_start`; counter cleared to 0.
  - LOAD: each `load_valid` cycle writes mem[counter]=`load_data` and increments the counter.
  - LOAD→RUN on a `load_valid` cycle with `load_last`=1, or after the write at counter=depth-1 (counter does not wrap).
  - RUN→IDLE on `run_stop`. `run_stop` is ignored outside RUN. `load_start` is ignored outside IDLE.
- `cpu_reset` is registered: 1 in IDLE and LOAD, 0 from the first cycle after the edge that enters RUN, and 1 again the cycle after leaving RUN. The CPU therefore starts fetching at pc=0 one cycle after RUN is entered.
- Read path: `cpu_data_in` = mem[`cpu_mem_addr`[ADDR_W-1:0]] when `cpu_mem_addr` < depth, else OOR_DATA. It is purely combinational because the CPU samples on the same edge the address is driven.
- Store decode (RUN only):
  - `armed` is set at the edge of any cycle where `cpu_data_out`==8'hFF and `armed`==0.
  - A cycle with `armed`==1 is a write cycle: at its edge, mem[`cpu_mem_addr`]=`cpu_data_out` (ignored if out of range) and `armed` clears.
  - A write cycle never re-arms, even if the stored value is 0xFF. This is what makes storing 0xFF safe.
- Outside RUN, `armed` is forced to 0 and CPU bus inputs are ignored.
- Known limitation: the CPU holding 0xFF on `cpu_data_out` for RET causes alternating arm/write cycles to its current address. This is accepted and must not be masked.
- Priority: `reset` > `run_stop` > store decode. A CPU write in the same cycle as `run_stop` is dropped.
- Reset mid-LOAD or mid-RUN: return to reset state and memory contents are lost.

Test Plan:
1. After reset: `cpu_reset`=1, `busy`=0, and `dbg_data`=0x0F for every address.
2. Load 08 03 08 04 00 0A 1F 0E (`load_last` on 0E) -> RUN; CPU runs PSI 3, PSI 4, ADD, STR 0x1F, RET. Required: mem[0x1F]=0x07 and `cpu_reset`=0 throughout the run.
3. Forced bus in RUN:
   - (addr 0x02, data 0xFF), then (0x10, 0x55), then (0x00, 0x00) -> only mem[0x10]=0x55 written.
   - (0x02, 0xFF), (0x11, 0xFF), (0x00, 0x00) -> mem[0x11]=0xFF, mem[0x00] unchanged.
4. `cpu_mem_addr`=0x40 in RUN -> `cpu_data_in`=0x0F. Marker then (0x40, 0x12) -> no memory word changes.
5. Load 32 bytes without `load_last` -> RUN entered after byte 31; mem[31] holds the last byte. A 33rd `load_valid` is ignored.
6. Cycles 3-4 of a STR, assert `run_stop` on the data cycle -> no write occurs, state=IDLE, `cpu_reset`=1 next cycle. Separately, assert `reset` during LOAD -> IDLE with all words 0x0F.
